// File: rtl/lfsr_fifo_pkg.sv
// lfsr_fifo_pkg: width helpers shared by the LFSR sample FIFO
// fifo_ptr_w(depth): pointer width; fifo_cnt_w(depth): occupancy width (0..depth)
package lfsr_fifo_pkg;
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: reset-less register array, sync write port, async read port
// clk; we/waddr/wdata write on posedge; raddr -> rdata combinational
module fifo_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/lfsr_sample_fifo.sv
// lfsr_sample_fifo: FWFT valid/ready FIFO buffering LFSR words, with flush, count and high-water mark
// clk, reset (sync, active-high), flush (sync clear); wr_valid/wr_data/wr_ready push side;
// rd_valid/rd_data/rd_ready pop side; count = occupancy; high_water = max count since reset
module lfsr_sample_fifo
    import lfsr_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                wr_valid,
    input  logic [FIFO_WIDTH-1:0]               wr_data,
    output logic                                wr_ready,
    output logic                                rd_valid,
    output logic [FIFO_WIDTH-1:0]               rd_data,
    input  logic                                rd_ready,
    output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]   count,
    output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]   high_water
);
    localparam int PW = fifo_ptr_w(FIFO_DEPTH);
    localparam int CW = fifo_cnt_w(FIFO_DEPTH);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("lfsr_sample_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic          push, pop;
    // reset also masks the handshakes so upstream never sees a word accepted during reset
    assign wr_ready = count != CW'(FIFO_DEPTH) && !flush && !reset;
    assign rd_valid = count != '0 && !flush && !reset;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign cnt_nxt  = flush ? '0 : count + CW'(push) - CW'(pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + PW'(push);
            rd_ptr <= flush ? '0 : rd_ptr + PW'(pop);
            count  <= cnt_nxt;
            if (cnt_nxt > high_water) high_water <= cnt_nxt;
        end
    end
    fifo_regfile #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// tb_lfsr_sample_fifo: directed table-driven and sequence checks for lfsr_sample_fifo
module tb_lfsr_sample_fifo;
    logic       clk = 1'b0;
    logic       reset, flush, wr_valid, wr_ready, rd_valid, rd_ready;
    logic [7:0] wr_data, rd_data;
    logic [5:0] count, high_water;
    int         total = 0;
    int         bad = 0;
    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       fl;
        logic       erdy;
        logic       ev;
        logic [7:0] ed;
        int         ecnt;
        int         ehw;
    } vec_t;
    vec_t tbl[10];
    always #5 clk = ~clk;
    lfsr_sample_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .count      (count),
        .high_water (high_water)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    task automatic drive(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
    endtask
    task automatic do_reset;
        reset = 1'b1;
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("rst_wr_ready_masked", {31'd0, wr_ready}, 32'd0);
        tick;
        tick;
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_count", {26'd0, count}, 32'd0);
        chk("rst_high_water", {26'd0, high_water}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    endtask
    initial begin
        // wv wd rr fl | wr_ready rd_valid rd_data count high_water (all before the edge)
        tbl[0] = '{1'b1, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5C, 1, 1};
        tbl[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1};
        tbl[3] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1, 1};
        tbl[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2, 2};
        tbl[5] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2, 2};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2};
        tbl[7] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1, 2};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2};
        do_reset;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
            chk($sformatf("tbl%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, tbl[i].erdy});
            chk($sformatf("tbl%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) chk($sformatf("tbl%0d_rd_data", i), {24'd0, rd_data}, {24'd0, tbl[i].ed});
            chk($sformatf("tbl%0d_count", i), {26'd0, count}, tbl[i].ecnt);
            chk($sformatf("tbl%0d_high_water", i), {26'd0, high_water}, tbl[i].ehw);
            tick;
        end
        // fill to full
        do_reset;
        for (int i = 1; i <= 32; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_wr_ready", {31'd0, wr_ready}, 32'd1);
            tick;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("full_count", {26'd0, count}, 32'd32);
        chk("full_high_water", {26'd0, high_water}, 32'd32);
        chk("full_rd_valid", {31'd0, rd_valid}, 32'd1);
        // pop at full with 0xAA pending: not accepted in the pop cycle
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("fullpop_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("fullpop_rd_data", {24'd0, rd_data}, 32'h01);
        tick;
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("afterpop_count", {26'd0, count}, 32'd31);
        chk("afterpop_wr_ready", {31'd0, wr_ready}, 32'd1);
        tick;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("refill_count", {26'd0, count}, 32'd32);
        chk("refill_wr_ready", {31'd0, wr_ready}, 32'd0);
        for (int i = 2; i <= 33; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_rd_valid", {31'd0, rd_valid}, 32'd1);
            chk($sformatf("drain_data%0d", i), {24'd0, rd_data}, i <= 32 ? i : 32'hAA);
            tick;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drained_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("drained_count", {26'd0, count}, 32'd0);
        // steady push+pop across pointer wrap
        do_reset;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick;
        end
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 8'(i + 5), 1'b1, 1'b0);
            chk("wrap_rd_valid", {31'd0, rd_valid}, 32'd1);
            chk("wrap_rd_data", {24'd0, rd_data}, {24'd0, 8'(i)});
            chk("wrap_count", {26'd0, count}, 32'd5);
            tick;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_end_count", {26'd0, count}, 32'd5);
        chk("wrap_high_water", {26'd0, high_water}, 32'd5);
        chk("wrap_end_data", {24'd0, rd_data}, 32'd100);
        // flush mid-stream at count=10
        do_reset;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            tick;
        end
        drive(1'b1, 8'hBB, 1'b1, 1'b1);
        chk("flush_count_before", {26'd0, count}, 32'd10);
        chk("flush_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("flush_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("postflush_count", {26'd0, count}, 32'd0);
        chk("postflush_high_water", {26'd0, high_water}, 32'd10);
        chk("postflush_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("postflush_next_valid", {31'd0, rd_valid}, 32'd1);
        chk("postflush_next_data", {24'd0, rd_data}, 32'h77);
        tick;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("postflush_empty", {26'd0, count}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
